fetch_axi_imem_slave: RTL and testbench

AXI4 read-only responder that serves instruction fetch bursts from a single-port synchronous instruction SRAM. It sits at the far end of the fetch AXI read channel, downstream of the fetch register slice, and implements the target side of that protocol. It accepts AR requests into a small queue, generates per-beat addresses for FIXED, INCR and WRAP bursts, and reads the SRAM with one-cycle latency. R beats are returned in order through a skid buffer that absorbs `rready` backpressure.

---
 rtl/fetch_axi_imem_slave_pkg.sv | 35 +++
 rtl/fetch_axi_imem_rskid.sv | 50 +++++
 rtl/fetch_axi_imem_slave.sv | 184 ++++++++++++++++++
 tb/tb_fetch_axi_imem_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_axi_imem_slave_pkg.sv
// Shared AXI encodings, AR queue entry layout and R beat layout for the
// instruction SRAM read responder.
package fetch_axi_imem_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  localparam logic [2:0] AXI_SIZE_WORD   = 3'd2;

  // R beat payload as carried through the output buffer: {rid, rdata, rresp, rlast}
  localparam int R_BEAT_W = 4 + 32 + 2 + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } eng_state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_entry_t;

  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/fetch_axi_imem_rskid.sv
// Two-entry R channel output buffer; o_data is held stable while o_valid && !i_ready.
// Valid/ready: a beat moves on a rising edge where valid and ready are both high.
module fetch_axi_imem_rskid
  import fetch_axi_imem_slave_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [R_BEAT_W-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [R_BEAT_W-1:0] o_data,
  output logic [1:0]          o_count
);

  logic                r_v0;
  logic                r_v1;
  logic [R_BEAT_W-1:0] r_d0;
  logic [R_BEAT_W-1:0] r_d1;
  logic                w_pop;

  assign w_pop   = r_v0 && i_ready;
  assign o_valid = r_v0;
  assign o_data  = r_d0;
  assign o_count = {1'b0, r_v0} + {1'b0, r_v1};

  // The producer only pushes when it holds a credit, so a push never meets two full entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (w_pop) begin
      r_v0 <= r_v1 || i_valid;
      r_d0 <= r_v1 ? r_d1 : i_data;
      r_v1 <= r_v1 && i_valid;
      if (r_v1 && i_valid) r_d1 <= i_data;
    end else if (i_valid) begin
      if (!r_v0) begin
        r_v0 <= 1'b1;
        r_d0 <= i_data;
      end else begin
        r_v1 <= 1'b1;
        r_d1 <= i_data;
      end
    end
  end

endmodule

// File: rtl/fetch_axi_imem_slave.sv
// AXI4 read-only responder serving fetch bursts from a 1-cycle-latency SRAM.
// Define FETCH_AXI_IMEM_WRAP_EN to serve WRAP bursts; otherwise they return SLVERR.
module fetch_axi_imem_slave
  import fetch_axi_imem_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h1FC0_0000,
  parameter int          MEM_AW    = 14,
  parameter int          AR_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        axi_s_arid,
  input  logic [31:0]       axi_s_araddr,
  input  logic [7:0]        axi_s_arlen,
  input  logic [2:0]        axi_s_arsize,
  input  logic [1:0]        axi_s_arburst,
  input  logic              axi_s_aruser,
  input  logic              axi_s_arvalid,
  output logic              axi_s_arready,
  output logic [3:0]        axi_s_rid,
  output logic [31:0]       axi_s_rdata,
  output logic [1:0]        axi_s_rresp,
  output logic              axi_s_rlast,
  output logic              axi_s_rvalid,
  input  logic              axi_s_rready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int PW = $clog2(AR_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(AR_DEPTH);

  ar_entry_t        r_q [AR_DEPTH];
  logic [PW-1:0]    r_q_rd;
  logic [PW-1:0]    r_q_wr;
  logic [CW-1:0]    r_q_cnt;
  logic [CW-1:0]    w_q_cnt_nxt;
  logic             r_run;
  logic             w_push;
  logic             w_pop;
  ar_entry_t        w_head;

  eng_state_t       r_state;
  eng_state_t       w_state_nxt;
  logic [7:0]       r_beat_cnt;
  logic [31:0]      r_beat_addr;
  logic [31:0]      w_cur_addr;
  logic [31:0]      w_next_addr;
  logic [1:0]       w_resp;
  logic             w_issue;
  logic             w_last;
  logic             w_space;
  logic [1:0]       w_occ;

  logic             r_pv;
  logic [3:0]       r_pid;
  logic [1:0]       r_presp;
  logic             r_plast;

  logic             w_skid_pop;
  logic [1:0]       w_skid_cnt;
  logic [R_BEAT_W-1:0] w_skid_in;
  logic [R_BEAT_W-1:0] w_skid_out;
  logic             w_unused_aruser;

  assign w_unused_aruser = axi_s_aruser;

  // r_run keeps arready low for the first cycle out of reset.
  assign axi_s_arready = r_run && (r_q_cnt != Q_FULL);
  assign w_push        = axi_s_arvalid && axi_s_arready;
  assign w_head        = r_q[r_q_rd];
  assign w_q_cnt_nxt   = r_q_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run   <= 1'b0;
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_q_cnt <= '0;
    end else begin
      r_run   <= 1'b1;
      r_q_cnt <= w_q_cnt_nxt;
      if (w_push) r_q_wr <= r_q_wr + PW'(1);
      if (w_pop)  r_q_rd <= r_q_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_q_wr] <= '{id: axi_s_arid, addr: axi_s_araddr, len: axi_s_arlen,
                                 size: axi_s_arsize, burst: axi_s_arburst};
  end

  // Credit: beats already in the buffer (after this cycle's pop) plus the read in flight.
  assign w_skid_pop = axi_s_rvalid && axi_s_rready;
  assign w_occ      = w_skid_cnt - {1'b0, w_skid_pop} + {1'b0, r_pv};
  assign w_space    = (w_occ < 2'd2);

`ifdef FETCH_AXI_IMEM_WRAP_EN
  logic [31:0] w_wrap_mask;
  assign w_wrap_mask = {22'd0, w_head.len, 2'b11};
`endif

  // The head entry is issued from the cycle it becomes visible, so IDLE costs no beat slot.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_addr  = (r_beat_cnt == 8'd0) ? w_head.addr : r_beat_addr;
    w_next_addr = w_cur_addr;
    w_resp      = AXI_RESP_OKAY;
    w_issue     = (r_q_cnt != '0) && w_space;
    w_last      = (r_beat_cnt == w_head.len);
    w_pop       = w_issue && w_last;

    if (w_head.size != AXI_SIZE_WORD) w_resp = AXI_RESP_SLVERR;
`ifdef FETCH_AXI_IMEM_WRAP_EN
    else if ((w_head.burst == AXI_BURST_WRAP) && !wrap_len_legal(w_head.len)) w_resp = AXI_RESP_SLVERR;
`else
    else if (w_head.burst == AXI_BURST_WRAP) w_resp = AXI_RESP_SLVERR;
`endif
    else if (w_cur_addr[31:MEM_AW+2] != ADDR_BASE[31:MEM_AW+2]) w_resp = AXI_RESP_DECERR;

    case (w_head.burst)
      AXI_BURST_FIXED: w_next_addr = w_cur_addr;
      AXI_BURST_INCR:  w_next_addr = w_cur_addr + 32'd4;
`ifdef FETCH_AXI_IMEM_WRAP_EN
      AXI_BURST_WRAP:  w_next_addr = (w_cur_addr & ~w_wrap_mask) | ((w_cur_addr + 32'd4) & w_wrap_mask);
`endif
      default:         w_next_addr = w_cur_addr;
    endcase

    case (r_state)
      ST_IDLE:  if (w_q_cnt_nxt != '0) w_state_nxt = ST_BURST;
      ST_BURST: if (w_q_cnt_nxt == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem_en   = w_issue && (w_resp == AXI_RESP_OKAY);
  assign mem_addr = mem_en ? w_cur_addr[MEM_AW+1:2] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_beat_addr <= '0;
      r_pv        <= 1'b0;
      r_pid       <= '0;
      r_presp     <= '0;
      r_plast     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pv    <= w_issue;
      if (w_issue) begin
        r_pid   <= w_head.id;
        r_presp <= w_resp;
        r_plast <= w_last;
        if (w_last) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt  <= r_beat_cnt + 8'd1;
          r_beat_addr <= w_next_addr;
        end
      end
    end
  end

  // Error beats never strobed the SRAM, so their data is forced to zero.
  assign w_skid_in = {r_pid, (r_presp == AXI_RESP_OKAY) ? mem_rdata : 32'd0, r_presp, r_plast};

  fetch_axi_imem_rskid u_rskid (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (r_pv),
    .i_data  (w_skid_in),
    .o_valid (axi_s_rvalid),
    .i_ready (axi_s_rready),
    .o_data  (w_skid_out),
    .o_count (w_skid_cnt)
  );

  assign {axi_s_rid, axi_s_rdata, axi_s_rresp, axi_s_rlast} = w_skid_out;

endmodule

// File: tb/tb_fetch_axi_imem_slave.sv
// Scoreboard bench for fetch_axi_imem_slave: AR driver, reference burst model, R monitor.
`timescale 1ns/1ps
module tb_fetch_axi_imem_slave;

  localparam logic [31:0] ADDR_BASE = 32'h1FC0_0000;
  localparam int          MEM_AW    = 14;
  localparam int          WIN_BYTES = 1 << (MEM_AW + 2);
  localparam int          W         = 39;

  logic              clk = 1'b0;
  logic              resetn;
  logic [3:0]        axi_s_arid;
  logic [31:0]       axi_s_araddr;
  logic [7:0]        axi_s_arlen;
  logic [2:0]        axi_s_arsize;
  logic [1:0]        axi_s_arburst;
  logic              axi_s_aruser;
  logic              axi_s_arvalid;
  logic              axi_s_arready;
  logic [3:0]        axi_s_rid;
  logic [31:0]       axi_s_rdata;
  logic [1:0]        axi_s_rresp;
  logic              axi_s_rlast;
  logic              axi_s_rvalid;
  logic              axi_s_rready = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  fetch_axi_imem_slave #(.ADDR_BASE(ADDR_BASE), .MEM_AW(MEM_AW), .AR_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .axi_s_arid(axi_s_arid), .axi_s_araddr(axi_s_araddr), .axi_s_arlen(axi_s_arlen),
    .axi_s_arsize(axi_s_arsize), .axi_s_arburst(axi_s_arburst), .axi_s_aruser(axi_s_aruser),
    .axi_s_arvalid(axi_s_arvalid), .axi_s_arready(axi_s_arready),
    .axi_s_rid(axi_s_rid), .axi_s_rdata(axi_s_rdata), .axi_s_rresp(axi_s_rresp),
    .axi_s_rlast(axi_s_rlast), .axi_s_rvalid(axi_s_rvalid), .axi_s_rready(axi_s_rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int beats_seen = 0;
  int mem_en_cnt = 0;
  int mem_snap = 0;
  int exp_okay = 0;
  int okay_snap = 0;
  int rr_mode = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word k holds k; output is junk in cycles that were not strobed.
  always @(posedge clk) mem_rdata <= mem_en ? {{(32-MEM_AW){1'b0}}, mem_addr} : 32'hDEAD_BEEF;

  always @(negedge clk) if (resetn === 1'b1 && mem_en === 1'b1) mem_en_cnt++;

  // rready pattern: 0 always high, 1 toggle, 2 random, 3 held low.
  always begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0: axi_s_rready = 1'b1;
      1: axi_s_rready = !axi_s_rready;
      2: axi_s_rready = 1'($urandom_range(0, 1));
      default: axi_s_rready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, base, cont, data;
    logic [1:0]  resp;
    bit          bad;
    cont = (32'(len) + 32'd1) * 32'd4;
    base = addr - (addr % cont);
    bad  = (size != 3'd2);
    if (burst == 2'd2) begin
`ifdef FETCH_AXI_IMEM_WRAP_EN
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) bad = 1'b1;
`else
      bad = 1'b1;
`endif
    end
    for (int k = 0; k <= int'(len); k++) begin
      case (burst)
        2'd1:    a = addr + 32'(4 * k);
        2'd2:    a = base + ((addr - base + 32'(4 * k)) % cont);
        default: a = addr;
      endcase
      if (bad) begin
        resp = 2'd2; data = 32'd0;
      end else if ((a >> (MEM_AW + 2)) != (ADDR_BASE >> (MEM_AW + 2))) begin
        resp = 2'd3; data = 32'd0;
      end else begin
        resp = 2'd0; data = (a >> 2) & 32'(WIN_BYTES / 4 - 1);
        exp_okay++;
      end
      exp_q.push_back({id, data, resp, (k == int'(len))});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    axi_s_arid = id; axi_s_araddr = addr; axi_s_arlen = len;
    axi_s_arsize = size; axi_s_arburst = burst; axi_s_aruser = 1'($urandom_range(0, 1));
    axi_s_arvalid = 1'b1;
    while (axi_s_arready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (axi_s_arready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ar_accept: got arready=%b after %0d cycles expected 1", axi_s_arready, n);
      axi_s_arvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      model_push(id, addr, len, size, burst);
    end
  endtask

  task automatic ar_idle();
    @(negedge clk);
    axi_s_arvalid = 1'b0;
  endtask

  task automatic check_latency(input string name);
    int n = 0;
    while (axi_s_rvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(cyc - hs_cyc), 64'd2);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    check({name, "_rvalid_idle"}, 64'(axi_s_rvalid), 64'd0);
    check({name, "_mem_en_count"}, 64'(mem_en_cnt - mem_snap), 64'(exp_okay - okay_snap));
    mem_snap  = mem_en_cnt;
    okay_snap = exp_okay;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] hold_q;
  bit           hold_pend = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] payload;
    payload = {axi_s_rid, axi_s_rdata, axi_s_rresp, axi_s_rlast};
    if (resetn !== 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("r_hold_valid", 64'(axi_s_rvalid), 64'd1);
        check("r_hold_payload", 64'(payload), 64'(hold_q));
      end
      hold_pend = 1'b0;
      if (axi_s_rvalid === 1'b1 && axi_s_rready === 1'b0) begin
        hold_pend = 1'b1;
        hold_q    = payload;
      end
      if (axi_s_rvalid === 1'b1 && axi_s_rready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_beat_unexpected: got 0x%0h expected no beat", payload);
        end else begin
          check($sformatf("r_beat%0d", beats_seen), 64'(payload), 64'(exp_q.pop_front()));
        end
        beats_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, b0;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  wl [4];
    wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

    resetn = 1'b0;
    axi_s_arid = '0; axi_s_araddr = '0; axi_s_arlen = '0; axi_s_arsize = '0;
    axi_s_arburst = '0; axi_s_aruser = 1'b0; axi_s_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arready", 64'(axi_s_arready), 64'd0);
    check("rst_rvalid", 64'(axi_s_rvalid), 64'd0);
    check("rst_rlast", 64'(axi_s_rlast), 64'd0);
    check("rst_rid", 64'(axi_s_rid), 64'd0);
    check("rst_rdata", 64'(axi_s_rdata), 64'd0);
    check("rst_rresp", 64'(axi_s_rresp), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("arready_after_reset", 64'(axi_s_arready), 64'd1);
    mem_snap = mem_en_cnt; okay_snap = exp_okay;

    rr_mode = 0;
    send_ar(4'h1, ADDR_BASE, 8'd3, 3'd2, 2'd1);
    ar_idle();
    check_latency("incr_latency");
    drain("incr");

    send_ar(4'h2, ADDR_BASE + 32'h8, 8'd3, 3'd2, 2'd2);
    ar_idle();
    drain("wrap");

    send_ar(4'h3, 32'h0000_1000, 8'd1, 3'd2, 2'd1);
    ar_idle();
    drain("decerr");

    send_ar(4'h4, ADDR_BASE + 32'(WIN_BYTES) - 32'd8, 8'd3, 3'd2, 2'd1);
    send_ar(4'h5, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'd1);
    ar_idle();
    drain("window_cross");

    send_ar(4'h6, ADDR_BASE + 32'h40, 8'd1, 3'd1, 2'd1);
    send_ar(4'h7, ADDR_BASE, 8'd2, 3'd2, 2'd2);
    send_ar(4'h8, ADDR_BASE + 32'h126, 8'd2, 3'd2, 2'd0);
    send_ar(4'h9, ADDR_BASE + 32'h3C, 8'd7, 3'd2, 2'd2);
    ar_idle();
    drain("slverr_fixed");

    rr_mode = 1;
    b0 = beats_seen;
    send_ar(4'hA, ADDR_BASE + 32'h200, 8'd7, 3'd2, 2'd1);
    ar_idle();
    drain("backpressure");
    check("backpressure_beats", 64'(beats_seen - b0), 64'd8);

    rr_mode = 0;
    send_ar(4'hB, ADDR_BASE + 32'h300, 8'd3, 3'd2, 2'd1);
    send_ar(4'hC, ADDR_BASE + 32'h400, 8'd3, 3'd2, 2'd1);
    ar_idle();
    n = 0;
    while (axi_s_rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (axi_s_rvalid === 1'b1 && n < 40) begin n++; @(negedge clk); end
    check("no_bubble_run", 64'(n), 64'd8);
    drain("no_bubble");

    rr_mode = 3;
    fork
      begin
        send_ar(4'hD, ADDR_BASE + 32'h500, 8'd3, 3'd2, 2'd1);
        send_ar(4'hE, ADDR_BASE + 32'h600, 8'd3, 3'd2, 2'd1);
        check("arready_full", 64'(axi_s_arready), 64'd0);
        send_ar(4'hF, ADDR_BASE + 32'h700, 8'd3, 3'd2, 2'd1);
      end
      begin
        repeat (10) @(posedge clk);
        rr_mode = 0;
      end
    join
    ar_idle();
    drain("queue_full");

    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       addr = $urandom();
        1:       addr = ADDR_BASE + 32'(WIN_BYTES) - 32'($urandom_range(1, 16) * 4);
        default: addr = ADDR_BASE + 32'($urandom_range(0, WIN_BYTES - 1));
      endcase
      burst = 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      len   = 8'($urandom_range(0, 15));
      if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = wl[$urandom_range(0, 3)];
      send_ar(4'($urandom_range(0, 15)), addr, len, size, burst);
      if ($urandom_range(0, 3) == 0) begin
        ar_idle();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    ar_idle();
    drain("random");

    rr_mode = 0;
    b0 = beats_seen;
    send_ar(4'h5, ADDR_BASE + 32'h800, 8'd15, 3'd2, 2'd1);
    ar_idle();
    n = 0;
    while ((beats_seen - b0) < 2 && n < 100) begin @(negedge clk); n++; end
    #1 resetn = 1'b0;
    #1;
    check("reset_mid_rvalid", 64'(axi_s_rvalid), 64'd0);
    check("reset_mid_arready", 64'(axi_s_arready), 64'd0);
    check("reset_mid_mem_en", 64'(mem_en), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mem_snap = mem_en_cnt; okay_snap = exp_okay;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (axi_s_rvalid === 1'b1) n++;
    end
    check("no_stale_after_reset", 64'(n), 64'd0);
    send_ar(4'h6, ADDR_BASE + 32'h20, 8'd3, 3'd2, 2'd1);
    ar_idle();
    check_latency("after_reset_latency");
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
